// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the multiplier result / BCD readout path.
package mul_pkg;

    localparam int unsigned MUL_W      = 16;
    localparam int unsigned BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StFin   = 2'd2
    } state_e;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/mul_result_bcd.sv
// Captures the multiplier product on a start strobe and converts it to packed BCD,
// one double-dabble shift per clock. Define BCD_LZB_EN for leading-zero blanking.
module mul_result_bcd
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH  = MUL_W,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  valid
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned SW   = 4 * DIGITS;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [SW-1:0]   scratch_q, scratch_adj, bcd_q, bcd_load;
    logic [CntW-1:0] cnt_q;
    logic            busy_q, done_q, valid_q;
    logic            start, shift_en, fin, last_shift;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    assign last_shift = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (st) state_d = StShift;
            StShift: if (last_shift) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start    = (state_q == StIdle) && st;
        shift_en = (state_q == StShift);
        fin      = (state_q == StFin);
        bcd      = bcd_q;
        busy     = busy_q;
        done     = done_q;
        valid    = valid_q;
    end

`ifdef BCD_LZB_EN
    logic lead;

    // Blank every digit above the most-significant nonzero one; units always shown.
    always_comb begin
        bcd_load = scratch_q;
        lead     = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (lead && (scratch_q[4*i +: 4] == 4'd0)) begin
                bcd_load[4*i +: 4] = BLANK_NIBBLE;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign bcd_load = scratch_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                shreg_q   <= bin;
                scratch_q <= '0;
                cnt_q     <= '0;
                busy_q    <= 1'b1;
            end else if (shift_en) begin
                {scratch_q, shreg_q} <= {scratch_adj[SW-2:0], shreg_q, 1'b0};
                cnt_q                <= cnt_q + 1'b1;
            end else if (fin) begin
                bcd_q   <= bcd_load;
                done_q  <= 1'b1;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

endmodule
